// File: rtl/ru_pkg.sv
// Shared types for the RU write-back stage.
// DEF_ADDRW / DEF_WL are the default address and data widths. The packed
// entry types take their field widths from these defaults, so a build that
// needs other widths changes them here rather than overriding the module
// parameters alone.
package ru_pkg;

  localparam int unsigned DEF_ADDRW = 16;
  localparam int unsigned DEF_WL    = 32;

  // One buffered write: destination address and value.
  typedef struct packed {
    logic [DEF_ADDRW-1:0] addr;
    logic [DEF_WL-1:0]    value;
  } wb_entry_t;

  // One in-flight tracking slot.
  typedef struct packed {
    logic                 busy;
    logic [DEF_ADDRW-1:0] addr;
  } track_entry_t;

endpackage

// File: rtl/ru_wb_fifo.sv
// Synchronous FIFO used as the write-back buffer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write one word (accepted when not full, or when full with pop)
//   pop           remove the head word (ignored when empty)
//   dout          head word
//   count         number of stored words
//   full, empty   status decoded from count
module ru_wb_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign dout  = mem[rptr];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ru_writeback.sv
// Write-back and hazard stage behind the reduce/update pipeline.
// Buffers RU results, drives the feature-memory write port, tracks every
// destination issued into RU but not yet written back, and freezes RU on
// read-after-write hazards or when the buffer/tracking table runs out of room.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ena, stall                     RU global enable and upstream stall
//   issue_valid, issue_src         address being issued into RU this cycle
//   in_valid, in_dst, in_value     RU output register
//   wr_ready                       memory accepts the write this cycle
//   wr_en, wr_addr, wr_data        memory write request (FIFO head)
//   stallwrite                     combinational freeze for RU
//   inflight                       number of busy tracking entries
module ru_writeback
  import ru_pkg::*;
#(
  parameter int unsigned ADDRW     = DEF_ADDRW,
  parameter int unsigned WL        = DEF_WL,
  parameter int unsigned TRACK     = 8,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       stall,
  input  logic                       issue_valid,
  input  logic [ADDRW-1:0]           issue_src,
  input  logic                       in_valid,
  input  logic [ADDRW-1:0]           in_dst,
  input  logic [WL-1:0]              in_value,
  input  logic                       wr_ready,
  output logic                       wr_en,
  output logic [ADDRW-1:0]           wr_addr,
  output logic [WL-1:0]              wr_data,
  output logic                       stallwrite,
  output logic [$clog2(TRACK+1)-1:0] inflight
);

  localparam int unsigned IW  = (TRACK > 1) ? $clog2(TRACK) : 1;
  localparam int unsigned CW  = $clog2(TRACK+1);
  localparam int unsigned FCW = $clog2(FIFODEPTH+1);
  localparam int unsigned EW  = $bits(wb_entry_t);

  track_entry_t   table_q [TRACK];
  logic [CW-1:0]  inflight_q;
  logic           adv_q;

  logic           advance;
  logic           hazard;
  logic           table_full;
  logic           fifo_near_full;
  logic           issue_hit;
  logic           free_hit;
  logic [IW-1:0]  free_idx;
  logic           alloc_found;
  logic [IW-1:0]  alloc_idx;
  logic           do_alloc;
  logic           do_free;

  logic           push;
  logic           pop;
  wb_entry_t      push_entry;
  wb_entry_t      head_entry;
  logic [EW-1:0]  fifo_dout;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  // CAM compares against issue and write addresses, plus lowest-free encoder.
  always_comb begin
    issue_hit   = 1'b0;
    free_hit    = 1'b0;
    free_idx    = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < int'(TRACK); i++) begin
      if (table_q[i].busy && (table_q[i].addr == issue_src)) begin
        issue_hit = 1'b1;
      end
      if (table_q[i].busy && (table_q[i].addr == wr_addr)) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    // Descending scan so the last assignment wins with the lowest index.
    for (int i = int'(TRACK) - 1; i >= 0; i--) begin
      if (!table_q[i].busy) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
  end

  // Stall terms look only at registered state; a free this cycle helps next cycle.
  assign hazard         = issue_valid & ena & issue_hit;
  assign table_full     = ~alloc_found;
  assign fifo_near_full = (fifo_count >= FCW'(FIFODEPTH - 1));
  assign stallwrite     = rst | hazard | table_full | fifo_near_full;
  assign advance        = ena & ~stall & ~stallwrite;

  assign do_alloc = advance & issue_valid;
  assign pop      = wr_en & wr_ready;
  assign do_free  = pop & free_hit;

  // RU output holds while frozen; adv_q marks the cycles holding a fresh result.
  assign push       = in_valid & adv_q;
  assign push_entry = '{addr: in_dst, value: in_value};

  // Tracking table, occupancy counter and advance history.
  always_ff @(posedge clk) begin
    if (rst) begin
      adv_q      <= 1'b0;
      inflight_q <= '0;
      for (int i = 0; i < int'(TRACK); i++) begin
        table_q[i] <= '0;
      end
    end else begin
      adv_q <= advance;
      // Free and allocate never target the same slot: allocation picks a free one.
      if (do_free) begin
        table_q[free_idx].busy <= 1'b0;
      end
      if (do_alloc) begin
        table_q[alloc_idx] <= '{busy: 1'b1, addr: issue_src};
      end
      inflight_q <= inflight_q + CW'(do_alloc) - CW'(do_free);
    end
  end

  ru_wb_fifo #(
    .W     (EW),
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write port is the FIFO head; it cannot move until the head is accepted.
  assign head_entry = wb_entry_t'(fifo_dout);
  assign wr_en      = ~fifo_empty;
  assign wr_addr    = head_entry.addr;
  assign wr_data    = head_entry.value;
  assign inflight   = inflight_q;

  // Every accepted write must retire a tracked destination.
  a_pop_tracked : assert property (@(posedge clk) disable iff (rst) pop |-> free_hit);

  // The near-full stall margin keeps the buffer from ever overflowing.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                   !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ru_writeback.sv
// Directed bench for ru_writeback: inputs change 1 time unit after the rising
// edge, outputs are checked on the falling edge.
module tb_ru_writeback;
  import ru_pkg::*;

  localparam int unsigned ADDRW     = 16;
  localparam int unsigned WL        = 32;
  localparam int unsigned TRACK     = 8;
  localparam int unsigned FIFODEPTH = 4;
  localparam int unsigned CW        = $clog2(TRACK+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             stall;
  logic             issue_valid;
  logic [ADDRW-1:0] issue_src;
  logic             in_valid;
  logic [ADDRW-1:0] in_dst;
  logic [WL-1:0]    in_value;
  logic             wr_ready;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [WL-1:0]    wr_data;
  logic             stallwrite;
  logic [CW-1:0]    inflight;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ru_writeback #(
    .ADDRW     (ADDRW),
    .WL        (WL),
    .TRACK     (TRACK),
    .FIFODEPTH (FIFODEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .stall       (stall),
    .issue_valid (issue_valid),
    .issue_src   (issue_src),
    .in_valid    (in_valid),
    .in_dst      (in_dst),
    .in_value    (in_value),
    .wr_ready    (wr_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .stallwrite  (stallwrite),
    .inflight    (inflight)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; stall = 1'b0;
    issue_valid = 1'b0; issue_src = '0;
    in_valid = 1'b0; in_dst = '0; in_value = '0;
    wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mid();
    chk("rst_stallwrite", stallwrite, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_inflight", inflight, 0);

    // Single update of address 5.
    nxt(); rst = 1'b0; ena = 1'b1; wr_ready = 1'b1;
    issue_valid = 1'b1; issue_src = 16'd5;
    mid(); chk("s1_issue_nostall", stallwrite, 0);
    nxt(); issue_valid = 1'b0; in_valid = 1'b1; in_dst = 16'd5; in_value = 32'h10;
    mid(); chk("s1_inflight1", inflight, 1);
    chk("s1_wr_en_before", wr_en, 0);
    nxt(); in_valid = 1'b0;
    mid(); chk("s1_wr_en", wr_en, 1);
    chk("s1_wr_addr", wr_addr, 5);
    chk("s1_wr_data", wr_data, 32'h10);
    nxt();
    mid(); chk("s1_inflight0", inflight, 0);
    chk("s1_drained", wr_en, 0);

    // RAW hazard on address 7.
    nxt(); issue_valid = 1'b1; issue_src = 16'd7;
    mid(); chk("raw_first_nostall", stallwrite, 0);
    nxt(); in_valid = 1'b1; in_dst = 16'd7; in_value = 32'h77;
    mid(); chk("raw_hazard", stallwrite, 1);
    chk("raw_inflight1", inflight, 1);
    nxt();
    mid(); chk("raw_wr_en", wr_en, 1);
    chk("raw_wr_addr", wr_addr, 7);
    chk("raw_wr_data", wr_data, 32'h77);
    chk("raw_still_stall", stallwrite, 1);
    nxt();
    mid(); chk("raw_unstall", stallwrite, 0);
    chk("raw_no_dup_push", wr_en, 0);
    nxt(); issue_valid = 1'b0; in_valid = 1'b1; in_dst = 16'd7; in_value = 32'h78;
    mid(); chk("raw_alloc_once", inflight, 1);
    nxt(); in_valid = 1'b0;
    mid(); chk("raw_second_data", wr_data, 32'h78);
    nxt();
    mid(); chk("raw_inflight0", inflight, 0);

    // Back-pressure: three results buffered with the memory not ready.
    nxt(); wr_ready = 1'b0; issue_valid = 1'b1; issue_src = 16'h0A;
    nxt(); issue_src = 16'h0B;
    nxt(); issue_src = 16'h0C;
    nxt(); issue_valid = 1'b0; in_valid = 1'b1; in_dst = 16'h0A; in_value = 32'hA0;
    mid(); chk("bp_cnt0_nostall", stallwrite, 0);
    nxt(); in_dst = 16'h0B; in_value = 32'hA1;
    mid(); chk("bp_head_valid", wr_en, 1);
    chk("bp_head_addr", wr_addr, 16'h0A);
    nxt(); in_dst = 16'h0C; in_value = 32'hA2;
    mid(); chk("bp_cnt2_nostall", stallwrite, 0);
    nxt(); in_valid = 1'b0;
    mid(); chk("bp_near_full", stallwrite, 1);
    chk("bp_head_stable", wr_addr, 16'h0A);
    chk("bp_inflight3", inflight, 3);
    nxt(); wr_ready = 1'b1;
    mid(); chk("bp_drain0_addr", wr_addr, 16'h0A);
    chk("bp_drain0_data", wr_data, 32'hA0);
    nxt();
    mid(); chk("bp_drain1_addr", wr_addr, 16'h0B);
    chk("bp_drain1_data", wr_data, 32'hA1);
    chk("bp_release", stallwrite, 0);
    nxt();
    mid(); chk("bp_drain2_addr", wr_addr, 16'h0C);
    chk("bp_drain2_data", wr_data, 32'hA2);
    nxt();
    mid(); chk("bp_empty", wr_en, 0);
    chk("bp_inflight0", inflight, 0);

    // Held RU output under a five-cycle upstream stall.
    nxt(); wr_ready = 1'b0; issue_valid = 1'b1; issue_src = 16'h40;
    nxt(); issue_valid = 1'b0; stall = 1'b1;
    in_valid = 1'b1; in_dst = 16'h40; in_value = 32'hBEEF;
    repeat (4) nxt();
    mid(); chk("hold_wr_en", wr_en, 1);
    chk("hold_wr_addr", wr_addr, 16'h40);
    nxt(); stall = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    mid(); chk("hold_wr_data", wr_data, 32'hBEEF);
    nxt();
    mid(); chk("hold_single_push", wr_en, 0);
    chk("hold_inflight0", inflight, 0);

    // Table full: eight distinct addresses outstanding.
    nxt(); wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1; issue_src = 16'h20 + 16'(i);
      mid(); chk("full_fill_nostall", stallwrite, 0);
      nxt();
    end
    issue_src = 16'h28; in_valid = 1'b1; in_dst = 16'h20; in_value = 32'h55;
    mid(); chk("full_stall", stallwrite, 1);
    chk("full_inflight8", inflight, 8);
    nxt(); wr_ready = 1'b1;
    mid(); chk("full_wr_addr", wr_addr, 16'h20);
    chk("full_still_stall", stallwrite, 1);
    nxt(); wr_ready = 1'b0;
    mid(); chk("full_one_freed", inflight, 7);
    chk("full_unstall", stallwrite, 0);
    nxt(); issue_valid = 1'b0; in_valid = 1'b0;
    mid(); chk("full_refilled", inflight, 8);
    chk("full_again", stallwrite, 1);

    // Reset discards everything, then rebuild 3 in flight / 2 buffered and reset.
    nxt(); rst = 1'b1;
    mid(); chk("rst1_stallwrite", stallwrite, 1);
    nxt(); rst = 1'b0; issue_valid = 1'b1; issue_src = 16'h30;
    mid(); chk("rst1_clean_nostall", stallwrite, 0);
    chk("rst1_inflight0", inflight, 0);
    nxt(); issue_src = 16'h31;
    nxt(); issue_src = 16'h32;
    nxt(); issue_valid = 1'b0; in_valid = 1'b1; in_dst = 16'h30; in_value = 32'h1;
    nxt(); in_dst = 16'h31; in_value = 32'h2;
    nxt(); in_valid = 1'b0;
    mid(); chk("rst2_pre_inflight", inflight, 3);
    chk("rst2_pre_wr_en", wr_en, 1);
    chk("rst2_pre_wr_addr", wr_addr, 16'h30);
    nxt(); rst = 1'b1;
    mid(); chk("rst2_stallwrite", stallwrite, 1);
    nxt(); rst = 1'b0;
    mid(); chk("rst2_wr_en", wr_en, 0);
    chk("rst2_inflight", inflight, 0);
    chk("rst2_stallwrite_low", stallwrite, 0);
    chk("rst2_wr_addr", wr_addr, 0);
    issue_valid = 1'b1; issue_src = 16'h30;
    nxt(); issue_valid = 1'b0;
    mid(); chk("rst2_realloc", inflight, 1);

    // ena low: no allocation.
    nxt(); ena = 1'b0; issue_valid = 1'b1; issue_src = 16'h50;
    mid(); chk("ena0_nostall", stallwrite, 0);
    nxt(); issue_valid = 1'b0; ena = 1'b1;
    mid(); chk("ena0_no_alloc", inflight, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
